sp_mem_req_bridge: RTL

- Request/response front end placed directly upstream of the single-port byte-write BRAM wrapper `sp_mem`.
- Converts a valid/ready request channel (byte-masked writes, reads) into the RAM's `addra`/`dina`/`wea`/`ena`/`regcea` strobes.
- Tracks the RAM's fixed read latency and returns read data in order on a valid/ready response channel.
- Holds read data in a credit-protected response FIFO, so back-pressure never loses data.

---
 rtl/sp_mem_req_bridge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sp_mem_req_bridge.sv
// Valid/ready request front end for the sp_mem BRAM wrapper: issues RAM strobes,
// tracks read latency and returns read data in order through a credit-protected FIFO.
// Optional power-on clear sweep: define SP_MEM_REQ_BRIDGE_CLEAR_EN.
module sp_mem_req_bridge #(
  parameter int NB_COL       = 2,
  parameter int COL_WIDTH    = 8,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clka,
  input  logic                          rsta,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [NB_COL-1:0]             req_we,
  input  logic [NB_COL*COL_WIDTH-1:0]   req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NB_COL*COL_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]             ram_addra,
  output logic [NB_COL*COL_WIDTH-1:0]   ram_dina,
  output logic [NB_COL-1:0]             ram_wea,
  output logic                          ram_ena,
  output logic                          ram_regcea,
  input  logic [NB_COL*COL_WIDTH-1:0]   ram_douta,
  output logic                          busy
);
  localparam int DW = NB_COL*COL_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH-1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  logic                    run, clearing, acc, rd_acc, credit, push, pop;
  logic [READ_LATENCY:1]   vld_pipe;
  logic [CW:0]             in_flight, used;
  logic [CW-1:0]           count;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [DW-1:0]           mem [FIFO_DEPTH];

`ifdef SP_MEM_REQ_BRIDGE_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clka) begin
    if (rsta) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) clr_addr <= clr_addr + A_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && (&clr_addr)) state_nxt = S_RUN;
  end

  assign run      = (state == S_RUN);
  assign clearing = (state == S_CLEAR);
`else
  assign run      = 1'b1;
  assign clearing = 1'b0;
`endif

  // Credits cover both words still inside the RAM pipeline and words already buffered.
  always_comb begin
    in_flight = '0;
    for (int s = 1; s <= READ_LATENCY; s++) in_flight = in_flight + (CW+1)'(vld_pipe[s]);
  end
  assign used   = in_flight + {1'b0, count};
  assign credit = used < (CW+1)'(FIFO_DEPTH);

  assign req_ready = !rsta && run && (credit || (|req_we));
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !(|req_we);

  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = '0;
    ram_addra = '0;
    ram_dina  = '0;
    if (acc) begin
      ram_ena   = 1'b1;
      ram_wea   = req_we;
      ram_addra = req_addr;
      ram_dina  = req_wdata;
    end
`ifdef SP_MEM_REQ_BRIDGE_CLEAR_EN
    else if (clearing && !rsta) begin
      ram_ena   = 1'b1;
      ram_wea   = '1;
      ram_addra = clr_addr;
    end
`endif
  end

  always_ff @(posedge clka) begin
    if (rsta) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= rd_acc;
      for (int s = 2; s <= READ_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign ram_regcea = !rsta && vld_pipe[1];
  assign push       = vld_pipe[READ_LATENCY];
  assign pop        = rsp_valid && rsp_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + P_ONE;
  endfunction

  always_ff @(posedge clka) begin
    if (rsta) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (push && !rsta) mem[wr_ptr] <= ram_douta;
  end

  assign rsp_valid = (count != '0);
  assign rsp_rdata = rsp_valid ? mem[rd_ptr] : '0;
  assign busy      = !rsta && ((|vld_pipe) || rsp_valid || clearing);

  // The credit check must make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clka) disable iff (rsta) !(push && !pop && count == C_FULL));
endmodule
